// File: rtl/conv1_maxpool.sv
// Optional ReLU then 2x2 stride-2 max pooling over the three conv1 feature
// streams, valid/ready on both sides, one pooled triple per 2x2 window.

module conv1_maxpool_lane #(
    parameter int DATA_W  = 23,
    parameter int LB_N    = 11,
    parameter int LBW     = 4,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_h,
    input  logic                     ld_lb,
    input  logic                     ld_out,
    input  logic [LBW-1:0]           idx,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] dout
);
    logic [LB_N-1:0][DATA_W-1:0] lbuf;
    logic signed [DATA_W-1:0]    x, hreg, hmax, vsel;

    always_comb begin
        x    = (RELU_EN && din[DATA_W-1]) ? '0 : din;
        hmax = (x > hreg) ? x : hreg;
        vsel = $signed(lbuf[idx]);
    end

    // lbuf carries the top-row pair max down to the odd row of the same window
    always_ff @(posedge clk) begin
        if (rst) begin
            hreg <= '0;
            lbuf <= '0;
            dout <= '0;
        end else begin
            if (ld_h)   hreg      <= x;
            if (ld_lb)  lbuf[idx] <= hmax;
            if (ld_out) dout      <= (vsel > hmax) ? vsel : hmax;
        end
    end
endmodule

module conv1_maxpool #(
    parameter int IN_W    = 22,
    parameter int IN_H    = 22,
    parameter int DATA_W  = 23,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] conv_in_1,
    input  logic signed [DATA_W-1:0] conv_in_2,
    input  logic signed [DATA_W-1:0] conv_in_3,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] pool_out_1,
    output logic signed [DATA_W-1:0] pool_out_2,
    output logic signed [DATA_W-1:0] pool_out_3,
    output logic                     valid_out,
    input  logic                     out_ready,
    output logic                     frame_done
);
    localparam int NUM_LANES = 3;
    localparam int LB_N      = IN_W / 2;
    localparam int LBW       = (LB_N > 1) ? $clog2(LB_N) : 1;
    localparam int CW        = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW        = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(IN_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IN_H - 1);
    localparam logic [CW-1:0] COL_PLAST = CW'(2 * (IN_W / 2) - 1);
    localparam logic [RW-1:0] ROW_PLAST = RW'(2 * (IN_H / 2) - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_flag;
    logic          accept, ld_h, ld_lb, ld_out, last_win;
    logic [LBW-1:0] idx;
    logic [NUM_LANES-1:0][DATA_W-1:0] din_v, dout_v;

    assign in_ready   = !valid_out || out_ready;
    assign accept     = valid_in && in_ready;
    assign ld_h       = accept && !col[0];
    assign ld_lb      = accept && col[0] && !row[0];
    assign ld_out     = accept && col[0] && row[0];
    assign idx        = LBW'(col >> 1);
    assign last_win   = (col == COL_PLAST) && (row == ROW_PLAST);
    assign frame_done = valid_out && out_ready && last_flag;

    assign din_v      = {conv_in_3, conv_in_2, conv_in_1};
    assign pool_out_1 = dout_v[0];
    assign pool_out_2 = dout_v[1];
    assign pool_out_3 = dout_v[2];

    // Odd trailing column/row is counted but never reaches an odd/odd slot
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            valid_out <= 1'b0;
            last_flag <= 1'b0;
        end else begin
            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (ld_out) begin
                valid_out <= 1'b1;
                last_flag <= last_win;
            end else if (valid_out && out_ready) begin
                valid_out <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        conv1_maxpool_lane #(
            .DATA_W (DATA_W),
            .LB_N   (LB_N),
            .LBW    (LBW),
            .RELU_EN(RELU_EN)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .ld_h  (ld_h),
            .ld_lb (ld_lb),
            .ld_out(ld_out),
            .idx   (idx),
            .din   ($signed(din_v[i])),
            .dout  (dout_v[i])
        );
    end
endmodule

// File: tb/tb_conv1_maxpool.sv
// Bench for conv1_maxpool: ReLU and raw 22x22 instances share stimulus and a
// scoreboard queue; a 5x5 instance covers the odd-size floor behaviour.

module tb_conv1_maxpool;
    localparam int W  = 22;
    localparam int H  = 22;
    localparam int DW = 23;
    localparam int NO = (W / 2) * (H / 2);
    localparam int NV = 5;

    typedef struct packed {
        logic signed [DW-1:0] a1, a2, a3, b1, b2, b3;
        logic                 last;
    } exp_t;

    typedef struct {
        logic signed [DW-1:0] w0, w1, w2, w3, er, en;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, valid_in, out_ready;
    logic signed [DW-1:0] in1, in2, in3;
    logic in_ready_a, vo_a, fd_a, in_ready_b, vo_b, fd_b;
    logic signed [DW-1:0] pa1, pa2, pa3, pb1, pb2, pb3;

    logic valid_in_c, out_ready_c, in_ready_c, vo_c, fd_c;
    logic signed [DW-1:0] inc1, inc2, inc3, pc1, pc2, pc3;

    conv1_maxpool u_a (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .conv_in_1(in1), .conv_in_2(in2), .conv_in_3(in3),
        .in_ready(in_ready_a), .pool_out_1(pa1), .pool_out_2(pa2), .pool_out_3(pa3),
        .valid_out(vo_a), .out_ready(out_ready), .frame_done(fd_a));

    conv1_maxpool #(.RELU_EN(1'b0)) u_b (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .conv_in_1(in1), .conv_in_2(in2), .conv_in_3(in3),
        .in_ready(in_ready_b), .pool_out_1(pb1), .pool_out_2(pb2), .pool_out_3(pb3),
        .valid_out(vo_b), .out_ready(out_ready), .frame_done(fd_b));

    conv1_maxpool #(.IN_W(5), .IN_H(5), .RELU_EN(1'b0)) u_c (
        .clk(clk), .rst(rst), .valid_in(valid_in_c),
        .conv_in_1(inc1), .conv_in_2(inc2), .conv_in_3(inc3),
        .in_ready(in_ready_c), .pool_out_1(pc1), .pool_out_2(pc2), .pool_out_3(pc3),
        .valid_out(vo_c), .out_ready(out_ready_c), .frame_done(fd_c));

    int ntot = 0, nbad = 0;
    int fd_cnt_a = 0, fd_cnt_b = 0, fdc = 0, exp_frames = 0;
    int rdy_mode = 0, stall_left = 0, stall_seen = 0;
    bit mon_en = 1'b0;
    exp_t sbq[$];
    logic signed [DW-1:0] got1[$], gotc[$];
    logic signed [DW-1:0] f1[H][W], f2[H][W], f3[H][W];
    vec_t vt[NV];

    task automatic chk(input string nm, input logic signed [DW-1:0] got,
                       input logic signed [DW-1:0] want);
        ntot++;
        if (got !== want) begin
            nbad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic chk_i(input string nm, input int got, input int want);
        ntot++;
        if (got != want) begin
            nbad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    function automatic logic signed [DW-1:0] smp(int ch, int r, int c);
        case (ch)
            1:       return f1[r][c];
            2:       return f2[r][c];
            default: return f3[r][c];
        endcase
    endfunction

    function automatic logic signed [DW-1:0] win_max(int ch, int r, int c);
        logic signed [DW-1:0] m, v;
        m = smp(ch, 2 * r, 2 * c);
        for (int k = 1; k < 4; k++) begin
            v = smp(ch, 2 * r + k / 2, 2 * c + k % 2);
            if (v > m) m = v;
        end
        return m;
    endfunction

    function automatic logic signed [DW-1:0] relu(logic signed [DW-1:0] v);
        return (v < 0) ? '0 : v;
    endfunction

    task automatic push_model();
        exp_t e;
        for (int r = 0; r < H / 2; r++)
            for (int c = 0; c < W / 2; c++) begin
                e.b1 = win_max(1, r, c);
                e.b2 = win_max(2, r, c);
                e.b3 = win_max(3, r, c);
                e.a1 = relu(e.b1);
                e.a2 = relu(e.b2);
                e.a3 = relu(e.b3);
                e.last = (r == H / 2 - 1) && (c == W / 2 - 1);
                sbq.push_back(e);
            end
        exp_frames++;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                f1[r][c] = DW'(r * W + c);
                f2[r][c] = -DW'(r * W + c);
                f3[r][c] = DW'(12);
            end
    endtask

    task automatic set_ready(output bit stl);
        stl = 1'b0;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(1) == 1);
            default:
                if (vo_a && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    stl = 1'b1;
                end else begin
                    out_ready = 1'b1;
                end
        endcase
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic send(input int gap, input int nsamp);
        int r, c, guard;
        bit acc, stl;
        for (int k = 0; k < nsamp; k++) begin
            r = k / W;
            c = k % W;
            guard = 0;
            do begin
                valid_in = ($urandom_range(99) >= gap);
                in1 = f1[r][c];
                in2 = f2[r][c];
                in3 = f3[r][c];
                set_ready(stl);
                #1;
                if (stl) begin
                    chk("stall_in_ready", in_ready_a, 0);
                    chk("stall_hold", pa1, 23);
                    stall_seen++;
                end
                acc = valid_in && in_ready_a;
                @(posedge clk);
                @(negedge clk);
                guard++;
            end while (!acc && guard < 1000);
            if (!acc) begin
                chk_i("send_timeout", guard, -1);
                valid_in = 1'b0;
                return;
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int guard;
        bit stl;
        guard = 0;
        valid_in = 1'b0;
        while (sbq.size() > 0 && guard < 5000) begin
            set_ready(stl);
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        if (sbq.size() != 0) chk_i("drain_timeout", sbq.size(), 0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic signed [DW-1:0] pick(vec_t v, int k);
        case (k)
            0:       return v.w0;
            1:       return v.w1;
            2:       return v.w2;
            default: return v.w3;
        endcase
    endfunction

    task automatic set_vec(input int i, input int a, input int b, input int c,
                           input int d, input int er, input int en);
        vt[i].w0 = DW'(a); vt[i].w1 = DW'(b); vt[i].w2 = DW'(c); vt[i].w3 = DW'(d);
        vt[i].er = DW'(er); vt[i].en = DW'(en);
    endtask

    function automatic logic signed [DW-1:0] cval(int f, int r, int c);
        return (r == 4 || c == 4) ? DW'(4000000) : DW'(r * 5 + c + f * 100);
    endfunction

    // Scoreboard monitor: inputs settle at negedge, transfer happens at next posedge
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (mon_en && !rst) begin
            if (vo_a && out_ready) begin
                if (sbq.size() == 0) begin
                    chk_i("unexpected_output", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("a_ch1", pa1, e.a1);
                    chk("a_ch2", pa2, e.a2);
                    chk("a_ch3", pa3, e.a3);
                    chk("b_ch1", pb1, e.b1);
                    chk("b_ch2", pb2, e.b2);
                    chk("b_ch3", pb3, e.b3);
                    chk("a_frame_done", fd_a, e.last);
                    chk("b_valid", vo_b, 1);
                    got1.push_back(pa1);
                end
            end
            if (fd_a) fd_cnt_a++;
            if (fd_b) fd_cnt_b++;
        end
        if (!rst && vo_c && out_ready_c) begin
            gotc.push_back(pc1);
            if (fd_c) fdc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        nbad++;
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; out_ready = 1'b1;
        in1 = '0; in2 = '0; in3 = '0;
        valid_in_c = 1'b0; out_ready_c = 1'b1; inc1 = '0; inc2 = '0; inc3 = '0;
        set_vec(0, -5, -3, -9, -1, 0, -1);
        set_vec(1, -4194304, 4194303, 0, 7, 4194303, 4194303);
        set_vec(2, -4194304, -4194304, -4194304, -4194304, 0, -4194304);
        set_vec(3, 100, -2, 5, 99, 100, 100);
        set_vec(4, 3, 3, 3, 3, 3, 3);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", vo_a, 0);
        chk("rst_pool1", pa1, 0);
        chk("rst_pool2", pa2, 0);
        chk("rst_pool3", pa3, 0);
        chk("rst_frame_done", fd_a, 0);
        chk("rst_c_valid", vo_c, 0);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", in_ready_a, 1);
        @(negedge clk);
        mon_en = 1'b1;

        // Clean ramp frame with constant ready
        fill_ramp();
        push_model();
        got1.delete();
        send(0, W * H);
        drain();
        chk_i("ramp_count", got1.size(), NO);
        if (got1.size() == NO) begin
            chk("ramp_out00", got1[0], 23);
            chk("ramp_out01", got1[1], 25);
            chk("ramp_out1010", got1[NO-1], 483);
        end
        chk_i("ramp_frame_done", fd_cnt_a, 1);

        // Five-cycle stall right after the first result
        rdy_mode = 2; stall_left = 5; stall_seen = 0;
        push_model();
        send(0, W * H);
        drain();
        chk_i("stall_cycles", stall_seen, 5);
        rdy_mode = 0;

        // Tiled-window vectors: every window of the frame is the table entry
        for (int i = 0; i < NV; i++) begin
            exp_t e;
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    f1[r][c] = pick(vt[i], (r % 2) * 2 + (c % 2));
                    f2[r][c] = f1[r][c];
                    f3[r][c] = f1[r][c];
                end
            e.a1 = vt[i].er; e.a2 = vt[i].er; e.a3 = vt[i].er;
            e.b1 = vt[i].en; e.b2 = vt[i].en; e.b3 = vt[i].en;
            for (int j = 0; j < NO; j++) begin
                e.last = (j == NO - 1);
                sbq.push_back(e);
            end
            exp_frames++;
            send(0, W * H);
            drain();
        end

        // Three back-to-back random frames, random gaps and backpressure
        rdy_mode = 1;
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    f1[r][c] = DW'($urandom);
                    f2[r][c] = DW'($urandom);
                    f3[r][c] = DW'($urandom);
                end
            push_model();
            send(50, W * H);
        end
        drain();
        rdy_mode = 0;
        chk_i("frames_a", fd_cnt_a, exp_frames);
        chk_i("frames_b", fd_cnt_b, exp_frames);

        // Abort a frame after 30 samples, then a clean frame
        mon_en = 1'b0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                f1[r][c] = DW'(1000000 + r * W + c);
                f2[r][c] = f1[r][c];
                f3[r][c] = f1[r][c];
            end
        send(0, 30);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid_out", vo_a, 0);
        chk("abort_pool1", pa1, 0);
        rst = 1'b0;
        #1 chk("abort_in_ready", in_ready_a, 1);
        @(negedge clk);
        mon_en = 1'b1;
        fill_ramp();
        push_model();
        got1.delete();
        send(0, W * H);
        drain();
        chk_i("abort_count", got1.size(), NO);
        if (got1.size() > 0) chk("abort_first", got1[0], 23);
        chk_i("frames_a_final", fd_cnt_a, exp_frames);

        // 5x5 instance: two frames back-to-back, trailing column/row are large
        gotc.delete();
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 25; k++) begin
                valid_in_c = 1'b1;
                inc1 = cval(f, k / 5, k % 5);
                inc2 = -inc1;
                inc3 = '0;
                @(negedge clk);
            end
        valid_in_c = 1'b0;
        repeat (4) @(negedge clk);
        chk_i("odd_count", gotc.size(), 8);
        if (gotc.size() == 8) begin
            for (int f = 0; f < 2; f++) begin
                chk("odd_w00", gotc[4*f+0], DW'(f * 100 + 6));
                chk("odd_w01", gotc[4*f+1], DW'(f * 100 + 8));
                chk("odd_w10", gotc[4*f+2], DW'(f * 100 + 16));
                chk("odd_w11", gotc[4*f+3], DW'(f * 100 + 18));
            end
        end
        chk_i("odd_frame_done", fdc, 2);

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end
endmodule
